// File: rtl/pq_traffic_gen.sv
// Fill/drain traffic generator for a min-first priority queue: enqueues LFSR keys, drains, checks order and count.
// Strobes are combinational from state and take effect on the same edge; busy stalls FILL/DRAIN and no strobe is issued while it is high.
module pq_traffic_gen #(
    parameter logic [7:0] MAX_N = 8'd16,
    parameter logic [7:0] SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        busy,
    input  logic        full,
    input  logic        empty,
    input  logic [15:0] kvo,
    output logic        enq,
    output logic        deq,
    output logic [15:0] kvi,
    output logic        done,
    output logic        err,
    output logic [7:0]  enq_cnt,
    output logic [7:0]  deq_cnt
);

    typedef enum logic [2:0] {IDLE, FILL, FWAIT, DRAIN, DWAIT, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lfsr;
    logic [7:0] prev_key;
    logic       launch;
    logic       finish;

    always_comb begin
        state_nxt = state;
        enq       = 1'b0;
        deq       = 1'b0;
        launch    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (!busy) begin
                    if (full || enq_cnt >= MAX_N) begin
                        state_nxt = DRAIN;
                    end else begin
                        enq       = 1'b1;
                        state_nxt = FWAIT;
                    end
                end
            end
            FWAIT: state_nxt = FILL;
            DRAIN: begin
                if (!busy) begin
                    if (empty) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        deq       = 1'b1;
                        state_nxt = DWAIT;
                    end
                end
            end
            DWAIT: state_nxt = DRAIN;
            default: state_nxt = IDLE;
        endcase
        kvi = enq ? {lfsr, enq_cnt} : 16'h0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enq_cnt  <= 8'd0;
            deq_cnt  <= 8'd0;
            err      <= 1'b0;
            done     <= 1'b0;
            lfsr     <= SEED;
            prev_key <= 8'd0;
        end else if (launch) begin
            enq_cnt  <= 8'd0;
            deq_cnt  <= 8'd0;
            err      <= 1'b0;
            done     <= 1'b0;
            lfsr     <= SEED;
            prev_key <= 8'd0;
        end else begin
            if (enq) begin
                enq_cnt <= enq_cnt + 8'd1;
                lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
            if (deq) begin
                prev_key <= kvo[15:8];
                // deq_cnt is zero only before the first dequeue, so it doubles as the first-dequeue flag
                if (deq_cnt != 8'd0 && kvo[15:8] < prev_key) err <= 1'b1;
                if (deq_cnt == 8'hFF) err <= 1'b1;
                else                  deq_cnt <= deq_cnt + 8'd1;
            end
            if (finish) begin
                done <= 1'b1;
                if (deq_cnt != enq_cnt) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pq_traffic_gen.sv
// Bench for pq_traffic_gen: behavioural priority-queue model with busy/full backpressure plus a kvi/key scoreboard.
module tb_pq_traffic_gen;

    localparam logic [7:0] MAXN = 8'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy = 1'b0;
    logic        full = 1'b0;
    logic        empty = 1'b1;
    logic [15:0] kvo = 16'h0000;
    logic        enq, deq, done, err;
    logic [15:0] kvi;
    logic [7:0]  enq_cnt, deq_cnt;

    pq_traffic_gen #(.MAX_N(MAXN), .SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .full(full), .empty(empty),
        .kvo(kvo), .enq(enq), .deq(deq), .kvi(kvi), .done(done), .err(err),
        .enq_cnt(enq_cnt), .deq_cnt(deq_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // queue model and scoreboard state
    logic [15:0] mq[$];
    logic [15:0] exp_kvi[$];
    logic [7:0]  exp_key[$];
    int          cap = 16;
    int          busy_len = 0;
    bit          faulty = 1'b0;
    int          busy_cnt = 0;
    int          enq_seen = 0;
    int          deq_seen = 0;
    bit          s_enq, s_deq;
    logic [15:0] s_kvi;

    function automatic int head_idx();
        int h = 0;
        if (faulty) return 0;
        for (int i = 1; i < mq.size(); i++)
            if (mq[i] < mq[h]) h = i;
        return h;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // monitor samples strobes at negedge; the model applies them just after the following posedge
    always begin
        @(negedge clk);
        s_enq = 1'b0;
        s_deq = 1'b0;
        if (!rst) begin
            if (enq || deq) chk("strobe_legal", ((enq && deq) || busy), 0);
            if (enq) begin
                s_enq = 1'b1;
                s_kvi = kvi;
                enq_seen++;
                if (exp_kvi.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_enq: kvi=%h with no enqueue expected", kvi);
                end else chk("kvi", kvi, exp_kvi.pop_front());
            end
            if (deq) begin
                s_deq = 1'b1;
                deq_seen++;
                if (exp_key.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_deq: key=%h with no dequeue expected", kvo[15:8]);
                end else chk("deq_key", kvo[15:8], exp_key.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            busy_cnt = 0;
        end else begin
            if (s_enq) mq.push_back(s_kvi);
            if (s_deq && mq.size() > 0) mq.delete(head_idx());
            if (s_enq || s_deq) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt--;
        end
        busy  = (busy_cnt > 0);
        empty = (mq.size() == 0);
        full  = (mq.size() >= cap);
        kvo   = empty ? 16'h0000 : mq[head_idx()];
    end

    // expected run outcome from the rules: n = min(MAX_N, capacity), keys from the LFSR, min-first drain
    task automatic prepare_run(input int capv, input bit flt, output int n, output bit e);
        logic [7:0] keys[$];
        logic [7:0] x = 8'hA5;
        logic [7:0] t;
        cap    = capv;
        faulty = flt;
        n      = (capv < int'(MAXN)) ? capv : int'(MAXN);
        e      = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_kvi.push_back({x, 8'(i)});
            keys.push_back(x);
            x = lfsr_next(x);
        end
        if (!flt) begin
            for (int i = 1; i < n; i++)
                for (int j = i; j > 0 && keys[j] < keys[j-1]; j--) begin
                    t = keys[j]; keys[j] = keys[j-1]; keys[j-1] = t;
                end
        end
        for (int i = 0; i < n; i++) begin
            exp_key.push_back(keys[i]);
            if (i > 0 && keys[i] < keys[i-1]) e = 1'b1;
        end
    endtask

    task automatic run_wait(input int n, input bit exp_err, input bit mid_err);
        int c;
        enq_seen = 0;
        deq_seen = 0;
        start = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        start = 1'b0;
        if (mid_err) begin
            for (c = 0; c < 1000 && deq_seen < 2; c++) @(posedge clk);
            @(negedge clk);
            chk("err_after_2nd_deq", err, 1);
        end
        for (c = 0; c < 3000 && !done; c++) @(negedge clk);
        chk("done", done, 1);
        chk("err", err, exp_err);
        chk("enq_cnt", enq_cnt, n);
        chk("deq_cnt", deq_cnt, n);
        chk("kvi_left", exp_kvi.size(), 0);
        chk("keys_left", exp_key.size(), 0);
        exp_kvi.delete();
        exp_key.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        bit e;
        int c;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_enq", enq, 0);
        chk("rst_deq", deq, 0);
        chk("rst_kvi", kvi, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_enq_cnt", enq_cnt, 0);
        chk("rst_deq_cnt", deq_cnt, 0);
        rst = 1'b0;
        enq_seen = 0;
        deq_seen = 0;
        repeat (10) @(negedge clk);
        chk("idle_strobes", enq_seen + deq_seen, 0);
        chk("idle_done", done, 0);
        chk("idle_err", err, 0);

        // MAX_N=4 with an ideal queue: literal sequence
        cap = 16; faulty = 1'b0; busy_len = 0;
        exp_kvi.push_back(16'hA500); exp_kvi.push_back(16'h4A01);
        exp_kvi.push_back(16'h9502); exp_kvi.push_back(16'h2A03);
        exp_key.push_back(8'h2A); exp_key.push_back(8'h4A);
        exp_key.push_back(8'h95); exp_key.push_back(8'hA5);
        run_wait(4, 1'b0, 1'b0);

        // queue full after 2 entries
        prepare_run(2, 1'b0, n, e);
        run_wait(n, e, 1'b0);

        // faulty queue returns A5 then 4A
        prepare_run(2, 1'b1, n, e);
        run_wait(n, e, 1'b1);

        // busy held 5 cycles after every strobe
        busy_len = 5;
        prepare_run(16, 1'b0, n, e);
        run_wait(n, e, 1'b0);

        // reset after the second enqueue, then a fresh run
        busy_len = 2;
        prepare_run(16, 1'b0, n, e);
        enq_seen = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < 500 && enq_seen < 2; c++) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_enq", enq, 0);
        chk("abort_deq", deq, 0);
        chk("abort_enq_cnt", enq_cnt, 0);
        chk("abort_kvi", kvi, 0);
        repeat (2) @(negedge clk);
        exp_kvi.delete();
        exp_key.delete();
        enq_seen = 0;
        deq_seen = 0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_strobes", enq_seen + deq_seen, 0);
        chk("post_rst_done", done, 0);
        prepare_run(16, 1'b0, n, e);
        run_wait(n, e, 1'b0);

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            busy_len = $urandom_range(0, 5);
            prepare_run($urandom_range(1, 6), ($urandom_range(0, 3) == 0), n, e);
            run_wait(n, e, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
